// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-ALU arbiter.
// The requester side uses master; the arbiter uses slave.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_ctrl;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_ctrl;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_result;
    logic [2:0]       resp_flags;

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_result, resp_flags
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_result, resp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// accept in IDLE, one EXEC cycle, then hold the response until consumed.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus,
    output logic [3:0]         alu_ctrl,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               alu_ovf
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             rr_ptr;
    logic             grant_id;
    logic             pick;
    logic             accept;
    logic             resp_done;
    logic [3:0]       op_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [2:0]       flags;

    // rr_ptr only breaks ties; a lone valid requester always wins.
    always_comb begin
        pick      = (bus.req0_valid & bus.req1_valid) ? rr_ptr : bus.req1_valid;
        accept    = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
        resp_done = (state == RESP) & (grant_id ? bus.resp1_ready : bus.resp0_ready);
    end

    assign bus.req0_ready  = accept & ~pick;
    assign bus.req1_ready  = accept & pick;
    assign bus.resp0_valid = (state == RESP) & ~grant_id;
    assign bus.resp1_valid = (state == RESP) & grant_id;
    assign bus.resp_result = res;
    assign bus.resp_flags  = flags;

    assign alu_ctrl = op_ctrl;
    assign alu_in1  = op_a;
    assign alu_in2  = op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            grant_id <= 1'b0;
            op_ctrl  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            flags    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_ctrl  <= pick ? bus.req1_ctrl : bus.req0_ctrl;
                        op_a     <= pick ? bus.req1_a    : bus.req0_a;
                        op_b     <= pick ? bus.req1_b    : bus.req0_b;
                        grant_id <= pick;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res   <= alu_result;
                    flags <= {alu_carry, alu_zero, alu_ovf};
                    state <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        rr_ptr <= ~grant_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU, per-cycle
// handshake model and a scoreboard of expected results per accepted request.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_ovf;

    alu_share_arbiter_if #(.WIDTH(32)) bus ();

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_ctrl   (alu_ctrl),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU: add (0000), sub (1000), xor otherwise. Returns {carry,zero,ovf,result}.
    function automatic logic [34:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        logic        o;
        case (c)
            4'b0000: begin t = {1'b0, a} + {1'b0, b}; o = (a[31] == b[31]) && (t[31] != a[31]); end
            4'b1000: begin t = {1'b0, a} - {1'b0, b}; o = (a[31] != b[31]) && (t[31] != a[31]); end
            default: begin t = {1'b0, a ^ b}; o = 1'b0; end
        endcase
        return {t[32], (t[31:0] == 32'd0), o, t[31:0]};
    endfunction

    always_comb {alu_carry, alu_zero, alu_ovf, alu_result} = alu_f(alu_ctrl, alu_in1, alu_in2);

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] r;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   m_phase = 0;
    bit   m_rr = 1'b0;
    bit   m_gid = 1'b0;
    bit   mon_en = 1'b0;

    // Cycle model: checks outputs for the current cycle, then predicts the next edge.
    always @(negedge clk) begin
        logic v0, v1, e0, e1;
        bit   g;
        exp_t e;
        if (mon_en) begin
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            e0 = (m_phase == 0) && v0 && (!v1 || !m_rr);
            e1 = (m_phase == 0) && v1 && (!v0 || m_rr);
            check("req0_ready", 64'(bus.req0_ready), 64'(e0));
            check("req1_ready", 64'(bus.req1_ready), 64'(e1));
            check("resp0_valid", 64'(bus.resp0_valid), 64'((m_phase == 2) && !m_gid));
            check("resp1_valid", 64'(bus.resp1_valid), 64'((m_phase == 2) && m_gid));
            if (v0 && bus.req0_ready) gnt_log.push_back(0);
            if (v1 && bus.req1_ready) gnt_log.push_back(1);
            if (m_phase == 1 && sb.size() > 0) begin
                check("alu_ctrl", 64'(alu_ctrl), 64'(sb[0].c));
                check("alu_in1", 64'(alu_in1), 64'(sb[0].a));
                check("alu_in2", 64'(alu_in2), 64'(sb[0].b));
            end
            if (m_phase == 2 && sb.size() > 0) begin
                check("resp_result", 64'(bus.resp_result), 64'(sb[0].r[31:0]));
                check("resp_flags", 64'(bus.resp_flags), 64'(sb[0].r[34:32]));
            end
            if (rst) begin
                m_phase = 0;
                m_rr    = 1'b0;
                sb.delete();
            end else begin
                case (m_phase)
                    0: if (v0 || v1) begin
                        g   = (v0 && v1) ? m_rr : v1;
                        e.c = g ? bus.req1_ctrl : bus.req0_ctrl;
                        e.a = g ? bus.req1_a : bus.req0_a;
                        e.b = g ? bus.req1_b : bus.req0_b;
                        e.r = alu_f(e.c, e.a, e.b);
                        sb.push_back(e);
                        m_gid   = g;
                        m_phase = 1;
                    end
                    1: m_phase = 2;
                    default: if (m_gid ? bus.resp1_ready : bus.resp0_ready) begin
                        void'(sb.pop_front());
                        m_rr    = !m_gid;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic send(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bit hs = 1'b0;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
        end
        while (!hs && n < 64) begin
            @(negedge clk);
            n++;
            hs = (p == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
        end
        check("send_accept", 64'(hs), 64'd1);
        @(posedge clk);
        #1;
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic expect_resp(input int p, input logic [31:0] r, input logic [2:0] f);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            seen = (p == 0) ? bus.resp0_valid : bus.resp1_valid;
        end
        check("resp_seen", 64'(seen), 64'd1);
        check("resp_value", 64'(bus.resp_result), 64'(r));
        check("resp_flag_bits", 64'(bus.resp_flags), 64'(f));
        check("resp_other_idle", 64'((p == 0) ? bus.resp1_valid : bus.resp0_valid), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_phase != 0 || sb.size() != 0 || bus.req0_valid || bus.req1_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(n < 100), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int log_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_ctrl = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_ctrl = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("rst_alu_in1", 64'(alu_in1), 64'd0);
        check("rst_alu_in2", 64'(alu_in2), 64'd0);
        check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        check("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
        check("rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
        check("rst_result", 64'(bus.resp_result), 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single requests with directed results
        send(0, 4'b0000, 32'd5, 32'd7);
        expect_resp(0, 32'd12, 3'b000);
        send(1, 4'b1000, 32'h1234, 32'h1234);
        expect_resp(1, 32'd0, 3'b010);
        send(0, 4'b0000, 32'h7FFF_FFFF, 32'd1);
        expect_resp(0, 32'h8000_0000, 3'b001);
        wait_idle();

        // Both ports contending from reset: grants alternate
        do_reset();
        gnt_log.delete();
        fork
            begin
                send(0, 4'b0000, 32'd100, 32'd23);
                send(0, 4'b1000, 32'd3, 32'd9);
            end
            begin
                send(1, 4'b0110, 32'hDEAD_BEEF, 32'hFFFF_0000);
                send(1, 4'b0000, 32'hFFFF_FFFF, 32'd1);
            end
        join
        wait_idle();
        check("alt_count", 64'(gnt_log.size()), 64'd4);
        check("alt_g0", 64'(log_at(0)), 64'd0);
        check("alt_g1", 64'(log_at(1)), 64'd1);
        check("alt_g2", 64'(log_at(2)), 64'd0);
        check("alt_g3", 64'(log_at(3)), 64'd1);

        // Response backpressure on port 0 while port 1 waits
        gnt_log.delete();
        bus.resp0_ready = 1'b0;
        fork
            begin
                send(0, 4'b0010, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
                send(0, 4'b0000, 32'd1, 32'd2);
            end
            send(1, 4'b0000, 32'd200, 32'd55);
            begin
                int n = 0;
                while (!bus.resp0_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_resp_seen", 64'(bus.resp0_valid), 64'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", 64'(bus.resp0_valid), 64'd1);
                    check("stall_result", 64'(bus.resp_result), 64'hAAAA_AAAA);
                    check("stall_req1_ready", 64'(bus.req1_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                bus.resp0_ready = 1'b1;
            end
        join
        wait_idle();
        check("stall_count", 64'(gnt_log.size()), 64'd3);
        check("stall_g0", 64'(log_at(0)), 64'd0);
        check("stall_g1", 64'(log_at(1)), 64'd1);
        check("stall_g2", 64'(log_at(2)), 64'd0);

        // Reset during EXEC aborts the op and restores port 0 priority
        send(1, 4'b0000, 32'd40, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_result", 64'(bus.resp_result), 64'd0);
        check("abort_alu_in1", 64'(alu_in1), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_resp", 64'(bus.resp1_valid | bus.resp0_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        gnt_log.delete();
        fork
            send(0, 4'b0000, 32'd11, 32'd22);
            send(1, 4'b0000, 32'd33, 32'd44);
        join
        wait_idle();
        check("post_rst_g0", 64'(log_at(0)), 64'd0);
        check("post_rst_g1", 64'(log_at(1)), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
